uart_tx: RTL and testbench

- 8N1 UART transmitter, LSB first. It is the transmit-side counterpart of uart_rx and uses the same bit-period parameter, so a uart_tx/uart_rx pair loops back directly.
- Has a one-entry holding register, so the bus-side master can queue the next byte while the current frame shifts out.
- Back-to-back frames leave no idle gap on tx.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_baud_counter.sv | 37 +++
 rtl/uart_tx.sv | 126 ++++++++++++
 tb/tb_uart_tx.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and framing constants.
// Used by both the transmitter and the receiver.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_e;

   localparam int UART_CLOCK_BIT_DEFAULT = 5208;
   localparam int UART_DATA_BITS         = 8;

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period counter: runs 0..uart_clock_bit-1, wraps, and flags the last cycle of each bit.
// Holding clear keeps it at 0 so the next bit starts on a full period.
module uart_baud_counter
   import uart_pkg::*;
#(
   parameter int uart_clock_bit = UART_CLOCK_BIT_DEFAULT
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   output logic tick
);

   localparam int                 CNT_W    = (uart_clock_bit > 1) ? $clog2(uart_clock_bit) : 1;
   localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(uart_clock_bit - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (clear || (cnt_q == CNT_LAST)) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick = (cnt_q == CNT_LAST) && !clear;

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter, LSB first, with a one-entry holding register so frames
// can run back to back without an idle gap. All outputs come straight from flops.
module uart_tx
   import uart_pkg::*;
#(
   parameter int uart_clock_bit = UART_CLOCK_BIT_DEFAULT
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      write,
   input  logic [UART_DATA_BITS-1:0] writedata,
   output logic                      tx,
   output logic                      ready,
   output logic                      busy,
   output logic                      done
);

   localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

   uart_state_e               state_q;
   logic [UART_DATA_BITS-1:0] shift_q;
   logic [UART_DATA_BITS-1:0] hold_q;
   logic [2:0]                bit_q;
   logic                      tx_q;
   logic                      ready_q;
   logic                      busy_q;
   logic                      done_q;

   logic baud_clear;
   logic baud_tick;
   logic accept;

   // Counter idles at 0, so START always begins on a fresh bit period.
   assign baud_clear = (state_q == IDLE);
   assign accept     = write && ready_q;

   uart_baud_counter #(
      .uart_clock_bit(uart_clock_bit)
   ) u_baud (
      .clock(clock),
      .reset(reset),
      .clear(baud_clear),
      .tick (baud_tick)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         shift_q <= '0;
         hold_q  <= '0;
         bit_q   <= '0;
         tx_q    <= 1'b1;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;

         // Mid-frame writes queue into the holding register; on the final stop
         // cycle an accepted write goes straight to the shifter instead.
         if (accept && (state_q != IDLE) && !((state_q == STOP) && baud_tick)) begin
            hold_q  <= writedata;
            ready_q <= 1'b0;
         end

         case (state_q)
            IDLE: begin
               if (accept) begin
                  shift_q <= writedata;
                  state_q <= START;
                  tx_q    <= 1'b0;
                  busy_q  <= 1'b1;
               end
            end
            START: begin
               if (baud_tick) begin
                  state_q <= DATA;
                  bit_q   <= '0;
                  tx_q    <= shift_q[0];
               end
            end
            DATA: begin
               if (baud_tick) begin
                  if (bit_q == LAST_BIT) begin
                     state_q <= STOP;
                     tx_q    <= 1'b1;
                  end else begin
                     shift_q <= shift_q >> 1;
                     tx_q    <= shift_q[1];
                     bit_q   <= bit_q + 1'b1;
                  end
               end
            end
            STOP: begin
               if (baud_tick) begin
                  done_q <= 1'b1;
                  if (!ready_q) begin
                     shift_q <= hold_q;
                     ready_q <= 1'b1;
                     state_q <= START;
                     tx_q    <= 1'b0;
                  end else if (accept) begin
                     shift_q <= writedata;
                     state_q <= START;
                     tx_q    <= 1'b0;
                  end else begin
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                  end
               end
            end
            default: begin
               state_q <= IDLE;
               tx_q    <= 1'b1;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign tx    = tx_q;
   assign ready = ready_q;
   assign busy  = busy_q;
   assign done  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: a bit-period-8 instance for framing, queueing and
// reset checks, plus a bit-period-2 instance for the minimum-period frame.
module tb_uart_tx;

   localparam int N  = 8;
   localparam int N2 = 2;

   logic       clock = 1'b0;
   logic       rst_n = 1'b0;
   logic       wr    = 1'b0;
   logic [7:0] wdata = 8'h00;
   logic       tx, ready, busy, done;

   logic       rst2_n = 1'b0;
   logic       wr2    = 1'b0;
   logic [7:0] wdata2 = 8'h00;
   logic       tx2, ready2, busy2, done2;

   always #5 clock = ~clock;

   uart_tx #(.uart_clock_bit(N)) dut (
      .clock(clock), .reset(rst_n), .write(wr), .writedata(wdata),
      .tx(tx), .ready(ready), .busy(busy), .done(done)
   );

   uart_tx #(.uart_clock_bit(N2)) dut2 (
      .clock(clock), .reset(rst2_n), .write(wr2), .writedata(wdata2),
      .tx(tx2), .ready(ready2), .busy(busy2), .done(done2)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Line monitor: decodes frames on tx by sampling mid-bit, records start cycles.
   logic [7:0] rxq[$];
   int         stq[$];
   int         done_cnt = 0;
   int         ferr     = 0;
   int         mpos     = -1;
   logic       prev_tx  = 1'b1;
   logic [7:0] msh      = 8'h00;

   initial forever begin
      @(posedge clock);
      cyc++;
   end

   initial forever begin
      @(negedge clock);
      if (done === 1'b1) done_cnt++;
      if (rst_n !== 1'b1) begin
         mpos = -1;
      end else begin
         if (mpos >= 0) begin
            mpos++;
            if (mpos == 10 * N) mpos = -1;
         end
         if (mpos < 0 && prev_tx === 1'b1 && tx === 1'b0) begin
            mpos = 0;
            stq.push_back(cyc);
         end
         if (mpos >= 0 && (mpos % N) == N / 2) begin
            if (mpos / N == 0) begin
               if (tx !== 1'b0) ferr++;
            end else if (mpos / N == 9) begin
               if (tx !== 1'b1) ferr++;
               rxq.push_back(msh);
            end else begin
               msh[mpos / N - 1] = tx;
            end
         end
      end
      prev_tx = tx;
   end

   task automatic send(input logic [7:0] b);
      @(posedge clock); #1;
      wr    = 1'b1;
      wdata = b;
      @(posedge clock); #1;
      wr    = 1'b0;
   endtask

   task automatic wait_idle(input int lim, input string tag);
      int k;
      k = 0;
      while (!(busy === 1'b0 && ready === 1'b1) && k < lim) begin
         @(negedge clock);
         k++;
      end
      chk(tag, 32'(k < lim), 32'd1);
   endtask

   task automatic expect_frame(input logic [7:0] b, output int errs);
      errs = 0;
      for (int k = 0; k < 10; k++) begin
         logic e;
         if (k == 0)      e = 1'b0;
         else if (k == 9) e = 1'b1;
         else             e = b[k-1];
         repeat (N) begin
            @(negedge clock);
            if (tx !== e || busy !== 1'b1) errs++;
         end
      end
   endtask

   logic [7:0] msg [5];
   int         errs;
   int         dc0;
   int         k;

   initial begin
      msg = '{8'hAA, 8'hAB, 8'hAC, 8'hAD, 8'hAF};

      repeat (3) @(negedge clock);
      chk("rst_tx",    32'(tx),    32'd1);
      chk("rst_ready", 32'(ready), 32'd1);
      chk("rst_busy",  32'(busy),  32'd0);
      chk("rst_done",  32'(done),  32'd0);
      @(posedge clock); #1;
      rst_n  = 1'b1;
      rst2_n = 1'b1;

      errs = 0;
      repeat (100) begin
         @(negedge clock);
         if (tx !== 1'b1 || ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) errs++;
      end
      chk("idle_hold", 32'(errs), 32'd0);

      // Single frame 0xAA, checked cycle by cycle
      rxq.delete(); stq.delete(); dc0 = done_cnt;
      send(8'hAA);
      expect_frame(8'hAA, errs);
      chk("aa_frame", 32'(errs), 32'd0);
      @(negedge clock);
      chk("aa_done",  32'(done), 32'd1);
      chk("aa_idle",  32'(busy), 32'd0);
      chk("aa_ready", 32'(ready), 32'd1);
      @(negedge clock);
      chk("aa_done_once", 32'(done), 32'd0);
      chk("aa_done_cnt",  32'(done_cnt - dc0), 32'd1);
      chk("aa_rx", (rxq.size() == 1) ? 32'(rxq[0]) : 32'hDEAD, 32'h0AA);

      // Five bytes written whenever ready: contiguous frames
      rxq.delete(); stq.delete(); dc0 = done_cnt;
      for (int i = 0; i < 5; i++) begin
         @(posedge clock); #1;
         k = 0;
         while (ready !== 1'b1 && k < 40 * N) begin
            @(posedge clock); #1;
            k++;
         end
         chk("burst_wr_ready", 32'(ready), 32'd1);
         wr    = 1'b1;
         wdata = msg[i];
         @(posedge clock); #1;
         wr    = 1'b0;
      end
      wait_idle(60 * N, "burst_idle");
      repeat (2) @(negedge clock);
      chk("burst_count", 32'(rxq.size()), 32'd5);
      for (int i = 0; i < 5; i++)
         chk("burst_byte", (i < rxq.size()) ? 32'(rxq[i]) : 32'hDEAD, 32'(msg[i]));
      for (int i = 0; i < 4; i++)
         chk("burst_spacing", (i + 1 < stq.size()) ? 32'(stq[i+1] - stq[i]) : 32'hDEAD, 32'(10 * N));
      chk("burst_done_cnt", 32'(done_cnt - dc0), 32'd5);
      chk("burst_framing", 32'(ferr), 32'd0);

      // Three writes in consecutive cycles: third one is dropped
      rxq.delete(); stq.delete();
      @(posedge clock); #1; wr = 1'b1; wdata = 8'h11;
      @(posedge clock); #1; wdata = 8'h22;
      @(posedge clock); #1; wdata = 8'h33;
      @(posedge clock); #1; wr = 1'b0;
      errs = 0;
      repeat (10 * N - 2) begin
         @(negedge clock);
         if (ready !== 1'b0) errs++;
      end
      chk("q3_ready_low", 32'(errs), 32'd0);
      @(negedge clock);
      chk("q3_ready_rise", 32'(ready), 32'd1);
      chk("q3_second_start", 32'(tx), 32'd0);
      chk("q3_busy", 32'(busy), 32'd1);
      wait_idle(30 * N, "q3_idle");
      repeat (12 * N) @(negedge clock);
      chk("q3_count", 32'(rxq.size()), 32'd2);
      chk("q3_byte0", (rxq.size() > 0) ? 32'(rxq[0]) : 32'hDEAD, 32'h11);
      chk("q3_byte1", (rxq.size() > 1) ? 32'(rxq[1]) : 32'hDEAD, 32'h22);
      chk("q3_tx_idle", 32'(tx), 32'd1);

      // Asynchronous reset in the middle of a data bit with a byte queued
      rxq.delete(); stq.delete(); dc0 = done_cnt;
      @(posedge clock); #1; wr = 1'b1; wdata = 8'h55;
      @(posedge clock); #1; wdata = 8'h66;
      @(posedge clock); #1; wr = 1'b0;
      repeat (2 * N + 3) @(negedge clock);
      chk("ar_pre_tx",    32'(tx),    32'd0);
      chk("ar_pre_ready", 32'(ready), 32'd0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_tx",    32'(tx),    32'd1);
      chk("ar_busy",  32'(busy),  32'd0);
      chk("ar_ready", 32'(ready), 32'd1);
      repeat (3) @(negedge clock);
      @(posedge clock); #1;
      rst_n = 1'b1;
      errs = 0;
      repeat (15 * N) begin
         @(negedge clock);
         if (tx !== 1'b1 || busy !== 1'b0 || ready !== 1'b1) errs++;
      end
      chk("ar_quiet", 32'(errs), 32'd0);
      chk("ar_no_rx", 32'(rxq.size()), 32'd0);
      chk("ar_no_done", 32'(done_cnt - dc0), 32'd0);

      // Minimum bit period: 0x80 frame spans 20 cycles
      @(posedge clock); #1; wr2 = 1'b1; wdata2 = 8'h80;
      @(posedge clock); #1; wr2 = 1'b0;
      errs = 0;
      for (int c = 0; c < 10 * N2; c++) begin
         logic e;
         @(negedge clock);
         e = (c / N2 == 8 || c / N2 == 9) ? 1'b1 : 1'b0;
         if (tx2 !== e || busy2 !== 1'b1) errs++;
      end
      chk("n2_frame", 32'(errs), 32'd0);
      @(negedge clock);
      chk("n2_done", 32'(done2), 32'd1);
      chk("n2_busy", 32'(busy2), 32'd0);
      chk("n2_tx",   32'(tx2),   32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule
